riscv_lsu: RTL and testbench

Load/store unit between the single-cycle core's data-memory port and a data RAM whose response latency is variable. It accepts the core's combinational access request (address, size, write data, write-enable), stalls the core until the RAM answers, and performs byte-lane steering for stores plus extraction and sign/zero-extension for loads. It also flags misaligned accesses, illegal sizes and RAM timeouts as errors.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/lsu_align.sv | 67 ++++++
 rtl/riscv_lsu.sv | 135 +++++++++++++
 tb/tb_riscv_lsu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store size codes (funct3), LSU state encoding
// and the latched LSU request payload.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   localparam logic [1:0] LSU_IDLE = 2'd0;
   localparam logic [1:0] LSU_BUSY = 2'd1;
   localparam logic [1:0] LSU_DONE = 2'd2;

   typedef struct packed {
      logic            we;
      logic [2:0]      size;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wd;
      logic [3:0]      be;
   } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational LSU datapath: legality check, store lane steering and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  lo,
   input  logic [31:0] wd,
   output logic        legal,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic [2:0]  ld_size,
   input  logic [1:0]  ld_lo,
   input  logic [31:0] rd,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Request side: unsigned sizes steer exactly like their signed twins.
   always_comb begin
      legal = 1'b0;
      be    = 4'b0000;
      wdata = wd;
      case (size)
         LDST_B, LDST_BU: begin
            legal = 1'b1;
            be    = 4'b0001 << lo;
            wdata = {4{wd[7:0]}};
         end
         LDST_H, LDST_HU: begin
            legal = ~lo[0];
            be    = lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{wd[15:0]}};
         end
         LDST_W: begin
            legal = (lo == 2'b00);
            be    = 4'b1111;
         end
         default: ;
      endcase
   end

   // Response side works from the latched size and low address bits.
   always_comb begin
      ld_byte = rd[7:0];
      case (ld_lo)
         2'd0: ld_byte = rd[7:0];
         2'd1: ld_byte = rd[15:8];
         2'd2: ld_byte = rd[23:16];
         2'd3: ld_byte = rd[31:24];
         default: ;
      endcase
      ld_half = ld_lo[1] ? rd[31:16] : rd[15:0];
      ld_data = 32'h0;
      case (ld_size)
         LDST_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         LDST_BU: ld_data = {24'h0, ld_byte};
         LDST_H:  ld_data = {{16{ld_half[15]}}, ld_half};
         LDST_HU: ld_data = {16'h0, ld_half};
         LDST_W:  ld_data = rd;
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: stalls the single-cycle core across a variable-latency
// data RAM access, with misalignment, illegal-size and timeout errors.
module riscv_lsu
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        core_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   lsu_req_t         req_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      rdata_q;
   logic             tout_q;

   logic             legal;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic [31:0]      ld_data;
   logic             accept;
   logic             complete;
   logic             timeout_hit;

   lsu_align u_align (
      .size    (core_size_i),
      .lo      (core_addr_i[1:0]),
      .wd      (core_wd_i),
      .legal   (legal),
      .be      (be),
      .wdata   (wdata),
      .ld_size (req_q.size),
      .ld_lo   (req_q.addr[1:0]),
      .rd      (mem_rd_i),
      .ld_data (ld_data)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= LSU_IDLE;
      else       state_q <= state_d;
   end

   // Next state and outputs; the IDLE stall/error are combinational so the
   // core never retires the access instruction in its first cycle.
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      complete     = 1'b0;
      timeout_hit  = 1'b0;
      core_rd_o    = 32'h0;
      core_stall_o = 1'b0;
      core_err_o   = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_be_o     = 4'b0000;
      mem_addr_o   = 32'h0;
      mem_wd_o     = 32'h0;
      case (state_q)
         LSU_IDLE: begin
            if (core_req_i) begin
               if (legal) begin
                  accept       = 1'b1;
                  core_stall_o = 1'b1;
                  state_d      = LSU_BUSY;
               end else begin
                  core_err_o = ~RESET;
               end
            end
         end
         LSU_BUSY: begin
            core_stall_o = 1'b1;
            mem_req_o    = 1'b1;
            mem_we_o     = req_q.we;
            mem_be_o     = req_q.be;
            mem_addr_o   = {req_q.addr[31:2], 2'b00};
            mem_wd_o     = req_q.wd;
            if (mem_ready_i) begin
               complete = 1'b1;
               state_d  = LSU_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_d     = LSU_DONE;
            end
         end
         LSU_DONE: begin
            core_rd_o  = rdata_q;
            core_err_o = tout_q;
            state_d    = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         req_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= 32'h0;
         tout_q  <= 1'b0;
      end else begin
         if (accept) begin
            req_q.we   <= core_we_i;
            req_q.size <= core_size_i;
            req_q.addr <= core_addr_i;
            req_q.wd   <= wdata;
            req_q.be   <= be;
         end
         if (state_q == LSU_BUSY) cnt_q <= cnt_q + CNT_W'(1);
         else                     cnt_q <= '0;
         if (complete)         rdata_q <= req_q.we ? 32'h0 : ld_data;
         else if (timeout_hit) rdata_q <= 32'h0;
         tout_q <= timeout_hit;
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: table of single accesses plus hand-written
// timeout, ready-outside-BUSY and reset-mid-access sequences.
module tb_riscv_lsu;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        core_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   int n_checks = 0;
   int n_errors = 0;

   riscv_lsu #(.TIMEOUT(4)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .core_req_i   (core_req_i),
      .core_we_i    (core_we_i),
      .core_size_i  (core_size_i),
      .core_addr_i  (core_addr_i),
      .core_wd_i    (core_wd_i),
      .core_rd_o    (core_rd_o),
      .core_stall_o (core_stall_o),
      .core_err_o   (core_err_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wd_o     (mem_wd_o),
      .mem_rd_i     (mem_rd_i),
      .mem_ready_i  (mem_ready_i)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          wait_cycles;
      logic        legal;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic we, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                               input int wait_cycles, input logic legal, input logic [3:0] be,
                               input logic [31:0] mwd, input logic [31:0] rdata);
      vec_t v;
      v.name = name; v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.rd = rd;
      v.wait_cycles = wait_cycles; v.legal = legal; v.be = be; v.mwd = mwd; v.rdata = rdata;
      return v;
   endfunction

   task automatic start_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd);
      core_req_i = 1'b1; core_we_i = we; core_size_i = size; core_addr_i = addr; core_wd_i = wd;
   endtask

   // One complete access: IDLE cycle, wait_cycles BUSY cycles, DONE cycle.
   task automatic run_vec(input vec_t v);
      @(negedge CLK);
      start_req(v.we, v.size, v.addr, v.wd);
      mem_ready_i = 1'b0; mem_rd_i = 32'h0;
      #2;
      if (!v.legal) begin
         check({v.name, "_err"},   32'(core_err_o),   32'd1);
         check({v.name, "_stall"}, 32'(core_stall_o), 32'd0);
         check({v.name, "_req"},   32'(mem_req_o),    32'd0);
         @(negedge CLK);
         core_req_i = 1'b0;
         #2;
         check({v.name, "_err_gone"}, 32'(core_err_o), 32'd0);
         check({v.name, "_req_gone"}, 32'(mem_req_o),  32'd0);
      end else begin
         check({v.name, "_idle_stall"}, 32'(core_stall_o), 32'd1);
         check({v.name, "_idle_req"},   32'(mem_req_o),    32'd0);
         check({v.name, "_idle_err"},   32'(core_err_o),   32'd0);
         for (int k = 1; k <= v.wait_cycles; k++) begin
            @(negedge CLK);
            if (k == v.wait_cycles) begin
               mem_ready_i = 1'b1;
               mem_rd_i    = v.rd;
            end
            #2;
            check({v.name, "_busy_req"},   32'(mem_req_o),    32'd1);
            check({v.name, "_busy_stall"}, 32'(core_stall_o), 32'd1);
            check({v.name, "_busy_rd"},    core_rd_o,         32'h0);
            if (k == 1) begin
               check({v.name, "_addr"}, mem_addr_o,       {v.addr[31:2], 2'b00});
               check({v.name, "_be"},   32'(mem_be_o),    32'(v.be));
               check({v.name, "_we"},   32'(mem_we_o),    32'(v.we));
               if (v.we) check({v.name, "_wd"}, mem_wd_o, v.mwd);
            end
         end
         @(negedge CLK);
         mem_ready_i = 1'b0; core_req_i = 1'b0; mem_rd_i = 32'hFFFF_FFFF;
         #2;
         check({v.name, "_done_stall"}, 32'(core_stall_o), 32'd0);
         check({v.name, "_done_rd"},    core_rd_o,         v.rdata);
         check({v.name, "_done_err"},   32'(core_err_o),   32'd0);
         check({v.name, "_done_req"},   32'(mem_req_o),    32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
      core_addr_i = 32'h0; core_wd_i = 32'h0; mem_rd_i = 32'h0; mem_ready_i = 1'b0;

      //           name     we    size  addr          wd            rd          wt legal be       mwd           rdata
      vecs.push_back(mk("sw",   1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 32'h1234_5678, 2, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0));
      vecs.push_back(mk("lb",   1'b0, 3'd0, 32'h0000_0203, 32'h0,         32'h80FF_0000, 1, 1'b1, 4'b1000, 32'h0, 32'hFFFF_FF80));
      vecs.push_back(mk("lbu",  1'b0, 3'd4, 32'h0000_0203, 32'h0,         32'h80FF_0000, 1, 1'b1, 4'b1000, 32'h0, 32'h0000_0080));
      vecs.push_back(mk("sh",   1'b1, 3'd1, 32'h0000_0012, 32'h0000_ABCD, 32'h0,         1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0));
      vecs.push_back(mk("lh",   1'b0, 3'd1, 32'h0000_0012, 32'h0,         32'h7FFF_1234, 1, 1'b1, 4'b1100, 32'h0, 32'h0000_7FFF));
      vecs.push_back(mk("lw_mis", 1'b0, 3'd2, 32'h0000_0102, 32'h0,       32'h0,         1, 1'b0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk("sz3",  1'b0, 3'd3, 32'h0000_0100, 32'h0,         32'h0,         1, 1'b0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk("lhu",  1'b0, 3'd5, 32'h0000_0022, 32'h0,         32'h8001_0000, 3, 1'b1, 4'b1100, 32'h0, 32'h0000_8001));
      vecs.push_back(mk("lh_lo", 1'b0, 3'd1, 32'h0000_0020, 32'h0,        32'h0000_9ABC, 1, 1'b1, 4'b0011, 32'h0, 32'hFFFF_9ABC));
      vecs.push_back(mk("sb",   1'b1, 3'd0, 32'h0000_0101, 32'h1234_56A5, 32'h0,         2, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0));
      vecs.push_back(mk("lw4",  1'b0, 3'd2, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 4, 1'b1, 4'b1111, 32'h0, 32'hCAFE_F00D));
      vecs.push_back(mk("lhu_mis", 1'b0, 3'd5, 32'h0000_0011, 32'h0,      32'h0,         1, 1'b0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk("sz7",  1'b1, 3'd7, 32'h0000_0100, 32'h0,         32'h0,         1, 1'b0, 4'b0000, 32'h0, 32'h0));
      vecs.push_back(mk("lb_pos", 1'b0, 3'd0, 32'h0000_0200, 32'h0,       32'hFFFF_FF7F, 1, 1'b1, 4'b0001, 32'h0, 32'h0000_007F));

      // Reset state.
      repeat (2) @(negedge CLK);
      #2;
      check("rst_mem_req",  32'(mem_req_o),    32'd0);
      check("rst_mem_we",   32'(mem_we_o),     32'd0);
      check("rst_mem_be",   32'(mem_be_o),     32'd0);
      check("rst_mem_addr", mem_addr_o,        32'h0);
      check("rst_mem_wd",   mem_wd_o,          32'h0);
      check("rst_core_rd",  core_rd_o,         32'h0);
      check("rst_err",      32'(core_err_o),   32'd0);
      check("rst_stall",    32'(core_stall_o), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;

      // Ready while IDLE must not start anything.
      mem_ready_i = 1'b1;
      @(negedge CLK);
      #2;
      check("idle_ready_req",   32'(mem_req_o),    32'd0);
      check("idle_ready_stall", 32'(core_stall_o), 32'd0);
      mem_ready_i = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Timeout: four BUSY cycles with no ready, then error pulse in DONE.
      @(negedge CLK);
      start_req(1'b0, 3'd2, 32'h0000_0300, 32'h0);
      #2;
      check("to_idle_stall", 32'(core_stall_o), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         #2;
         check("to_busy_req", 32'(mem_req_o),  32'd1);
         check("to_busy_err", 32'(core_err_o), 32'd0);
      end
      @(negedge CLK);
      core_req_i = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'h5555_5555;
      #2;
      check("to_done_err",   32'(core_err_o),   32'd1);
      check("to_done_rd",    core_rd_o,         32'h0);
      check("to_done_stall", 32'(core_stall_o), 32'd0);
      check("to_done_req",   32'(mem_req_o),    32'd0);
      @(negedge CLK);
      #2;
      check("to_after_err", 32'(core_err_o), 32'd0);
      check("to_after_req", 32'(mem_req_o),  32'd0);
      mem_ready_i = 1'b0;

      // Reset in the second BUSY cycle drops the request at once.
      @(negedge CLK);
      start_req(1'b0, 3'd2, 32'h0000_0400, 32'h0);
      @(negedge CLK);
      @(negedge CLK);
      #2;
      check("rm_busy2_req", 32'(mem_req_o), 32'd1);
      RESET = 1'b1;
      #1;
      check("rm_req_drop", 32'(mem_req_o),  32'd0);
      check("rm_addr",     mem_addr_o,      32'h0);
      check("rm_err",      32'(core_err_o), 32'd0);
      core_req_i = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      #2;
      check("rm_idle_req",   32'(mem_req_o),    32'd0);
      check("rm_idle_stall", 32'(core_stall_o), 32'd0);
      @(negedge CLK);
      #2;
      check("rm_idle2_req", 32'(mem_req_o),  32'd0);
      check("rm_idle2_err", 32'(core_err_o), 32'd0);

      // Recovery access after the abandoned one.
      run_vec(vecs[1]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
